// File: rtl/param_control_unit_if.sv
// Bus bundle between the control unit and its flash, PC, ALU, register file, SRAM and GPIO.
interface param_control_unit_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PC_W   = 12
);
    logic [7:0]        flash_data;
    logic              flash_valid;
    logic [PC_W-1:0]   pc_value;
    logic [DATA_W-1:0] sram_read_data;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] in_gpio;
    logic [DATA_W-1:0] reg_read_data_a;
    logic [DATA_W-1:0] reg_read_data_b;
    logic              a_greater;
    logic              a_equal;
    logic              carry_out;
    logic              bootstrapping;

    logic [2:0]        alu_opcode;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] sram_write_data;
    logic [DATA_W-1:0] reg_write_data;
    logic [DATA_W-1:0] out_gpio;
    logic [7:0]        sram_addr;
    logic              sram_write_en;
    logic              reg_write_en;
    logic              pc_load;
    logic              pc_inc;
    logic              out_valid;
    logic [PC_W-1:0]   pc_next;
    logic [3:0]        reg_write_addr;
    logic [3:0]        reg_read_addr_a;
    logic [3:0]        reg_read_addr_b;
    logic [1:0]        state;
    logic [15:0]       instruction;
    logic              halted;
    logic              stack_err;

    modport master (
        input  flash_data, flash_valid, pc_value, sram_read_data, alu_result, in_gpio,
               reg_read_data_a, reg_read_data_b, a_greater, a_equal, carry_out, bootstrapping,
        output alu_opcode, alu_a, alu_b, sram_write_data, reg_write_data, out_gpio,
               sram_addr, sram_write_en, reg_write_en, pc_load, pc_inc, out_valid,
               pc_next, reg_write_addr, reg_read_addr_a, reg_read_addr_b,
               state, instruction, halted, stack_err
    );

    modport slave (
        output flash_data, flash_valid, pc_value, sram_read_data, alu_result, in_gpio,
               reg_read_data_a, reg_read_data_b, a_greater, a_equal, carry_out, bootstrapping,
        input  alu_opcode, alu_a, alu_b, sram_write_data, reg_write_data, out_gpio,
               sram_addr, sram_write_en, reg_write_en, pc_load, pc_inc, out_valid,
               pc_next, reg_write_addr, reg_read_addr_a, reg_read_addr_b,
               state, instruction, halted, stack_err
    );
endinterface

// File: rtl/param_control_unit.sv
// Two-byte fetch / one-cycle execute control unit with latched ALU flags and a return stack.
module param_control_unit #(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned PC_W        = 12,
    parameter int unsigned STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 arst,
    param_control_unit_if.master bus
);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SP_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        FETCH_HIGH = 2'b00,
        FETCH_LOW  = 2'b01,
        EXECUTE    = 2'b10,
        HALT       = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        high_q;
    logic [15:0]       instr_q;
    logic [2:0]        flags_q;   // {gt, eq, c}
    logic [SP_W-1:0]   sp_q;
    logic [PC_W-1:0]   stack_mem [STACK_DEPTH];
    logic              stack_err_q;
    logic              halted_q;
    logic [DATA_W-1:0] out_gpio_q;

    logic [3:0]      op, dst, fa, fb;
    logic [PC_W-1:0] target, stack_top;
    logic            stack_full, stack_empty, is_alu, push_ok;

    assign op          = instr_q[15:12];
    assign dst         = instr_q[11:8];
    assign fa          = instr_q[7:4];
    assign fb          = instr_q[3:0];
    assign target      = PC_W'(instr_q[11:0]);
    assign stack_full  = (sp_q == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp_q == '0);
    assign stack_top   = stack_mem[IDX_W'(sp_q - SP_W'(1))];
    assign is_alu      = (op < 4'h6);
    assign push_ok     = (state_q == EXECUTE) && !arst && (op == 4'h7) && !stack_full;

    assign bus.state       = state_q;
    assign bus.instruction = instr_q;
    assign bus.halted      = halted_q;
    assign bus.stack_err   = stack_err_q;
    assign bus.out_gpio    = out_gpio_q;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state_q <= FETCH_HIGH;
        else      state_q <= state_d;
    end

    // Next state plus all combinational strobes and datapath steering.
    always_comb begin
        state_d             = state_q;
        bus.pc_inc          = 1'b0;
        bus.pc_load         = 1'b0;
        bus.pc_next         = '0;
        bus.alu_opcode      = 3'b001;
        bus.alu_a           = '0;
        bus.alu_b           = '0;
        bus.sram_addr       = '0;
        bus.sram_write_data = '0;
        bus.sram_write_en   = 1'b0;
        bus.reg_write_data  = '0;
        bus.reg_write_en    = 1'b0;
        bus.reg_write_addr  = dst;
        bus.reg_read_addr_a = '0;
        bus.reg_read_addr_b = '0;
        bus.out_valid       = 1'b0;
        case (state_q)
            FETCH_HIGH: if (bus.flash_valid) begin
                bus.pc_inc = !arst;
                state_d    = FETCH_LOW;
            end
            FETCH_LOW: if (bus.flash_valid) begin
                bus.pc_inc = !arst;
                state_d    = EXECUTE;
            end
            EXECUTE: begin
                state_d = (op == 4'h6 && dst == 4'h1) ? HALT : FETCH_HIGH;
                case (op)
                    4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                        bus.reg_read_addr_a = fa;
                        bus.reg_read_addr_b = fb;
                        bus.alu_a           = bus.reg_read_data_a;
                        bus.alu_b           = bus.reg_read_data_b;
                        bus.alu_opcode      = op[2:0];
                        bus.reg_write_data  = bus.alu_result;
                        bus.reg_write_en    = 1'b1;
                    end
                    4'h6: if (dst == 4'h0 && !stack_empty) begin
                        bus.pc_load = 1'b1;
                        bus.pc_next = stack_top;
                    end
                    4'h7: if (!stack_full) begin
                        bus.pc_load = 1'b1;
                        bus.pc_next = target;
                    end
                    4'h8: begin
                        bus.sram_addr      = {fa, fb};
                        bus.reg_write_data = bus.sram_read_data;
                        bus.reg_write_en   = 1'b1;
                    end
                    4'h9: begin
                        bus.reg_read_addr_a = dst;
                        bus.sram_addr       = {fa, fb};
                        bus.sram_write_data = bus.reg_read_data_a;
                        bus.sram_write_en   = 1'b1;
                    end
                    4'hA: begin
                        bus.pc_load = 1'b1;
                        bus.pc_next = target;
                    end
                    4'hB, 4'hC, 4'hD: begin
                        bus.pc_load = (op == 4'hB) ? flags_q[1] :
                                      (op == 4'hC) ? flags_q[2] : flags_q[0];
                        bus.pc_next = target;
                    end
                    4'hE: begin
                        bus.reg_write_data = bus.bootstrapping ? DATA_W'(bus.flash_data) : bus.in_gpio;
                        bus.reg_write_en   = 1'b1;
                    end
                    4'hF: begin
                        bus.reg_read_addr_a = dst;
                        bus.out_valid       = 1'b1;
                    end
                    default: ;
                endcase
            end
            HALT: ;
            default: ;
        endcase
    end

    // Fetch latches, flags, stack pointer and sticky status.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            high_q      <= '0;
            instr_q     <= '0;
            flags_q     <= '0;
            sp_q        <= '0;
            stack_err_q <= 1'b0;
            halted_q    <= 1'b0;
            out_gpio_q  <= '0;
        end else begin
            case (state_q)
                FETCH_HIGH: if (bus.flash_valid) high_q <= bus.flash_data;
                FETCH_LOW:  if (bus.flash_valid) instr_q <= {high_q, bus.flash_data};
                EXECUTE: begin
                    if (is_alu) flags_q <= {bus.a_greater, bus.a_equal, bus.carry_out};
                    if (op == 4'h6 && dst == 4'h0) begin
                        if (stack_empty) stack_err_q <= 1'b1;
                        else             sp_q <= sp_q - SP_W'(1);
                    end
                    if (op == 4'h6 && dst == 4'h1) halted_q <= 1'b1;
                    if (op == 4'h7) begin
                        if (stack_full) stack_err_q <= 1'b1;
                        else            sp_q <= sp_q + SP_W'(1);
                    end
                    if (op == 4'hF) out_gpio_q <= bus.reg_read_data_a;
                end
                default: ;
            endcase
        end
    end

    // Stack storage carries no reset; emptiness is tracked by sp_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) stack_mem[IDX_W'(sp_q)] <= bus.pc_value;
    end
endmodule

// File: doc/param_control_unit.md
PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

Interface
REQ-001 Parameter DATA_W, 8, datapath/register/GPIO width.
REQ-002 Parameter PC_W, 12, program counter width; legal range 12..16; 12-bit targets zero-extended.
REQ-003 Parameter STACK_DEPTH, 4, return-stack entries; power of two, 2..16.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 arst  in  1  asynchronous, active-high reset.
REQ-006 flash_data  in  8  program byte; flash_valid  in  1  byte valid this cycle.
REQ-007 pc_value  in  PC_W  current PC (address of next instruction during EXECUTE).
REQ-008 sram_read_data, alu_result, in_gpio, reg_read_data_a, reg_read_data_b  in  DATA_W each.
REQ-009 a_greater, a_equal, carry_out  in  1 each  ALU flags; bootstrapping  in  1  IN takes flash_data.
REQ-010 alu_opcode  out  3; alu_a, alu_b, sram_write_data, reg_write_data, out_gpio  out  DATA_W each.
REQ-011 sram_addr  out  8; sram_write_en, reg_write_en, pc_load, pc_inc, out_valid  out  1 each.
REQ-012 pc_next  out  PC_W; reg_write_addr, reg_read_addr_a, reg_read_addr_b  out  4 each.
REQ-013 state  out  2; instruction  out  16; halted  out  1; stack_err  out  1 sticky.

Function
REQ-014 States: FETCH_HIGH=00, FETCH_LOW=01, EXECUTE=10, HALT=11.
REQ-015 FETCH_HIGH: with flash_valid=1 latch high byte, go FETCH_LOW; else stay.
REQ-016 FETCH_LOW: with flash_valid=1 instruction <= {high, flash_data}, go EXECUTE; else stay.
REQ-017 pc_inc = 1 only in FETCH_HIGH/FETCH_LOW cycles with flash_valid=1.
REQ-018 EXECUTE lasts one cycle, then FETCH_HIGH (HALT on HALT opcode).
REQ-019 Fields: op=[15:12], dst=[11:8], a=[7:4], b=[3:0]; target={dst,a,b}.
REQ-020 Strobes (reg_write_en, sram_write_en, pc_load, out_valid) combinational, high only in EXECUTE; all other cycles 0.
REQ-021 Outside EXECUTE: alu_opcode=001, alu_a/alu_b/sram_addr/sram_write_data/reg_write_data=0, reg_write_addr=dst.
REQ-022 op 0x0-0x5 ALU: read a,b; alu_a/alu_b = read data; alu_opcode=op[2:0]; write alu_result to dst; latch flags.
REQ-023 Flag register {gt,eq,c} reset 0; updated only at ALU-op EXECUTE edge from a_greater/a_equal/carry_out.
REQ-024 op 0x6 SYS: dst=0 RET, dst=1 HALT, other dst values NOP.
REQ-025 op 0x7 CALL: push pc_value, pc_next=target, pc_load=1.
REQ-026 op 0x8 LOAD: sram_addr={a,b}, write sram_read_data to dst.
REQ-027 op 0x9 STORE: read_addr_a=dst, sram_addr={a,b}, sram_write_data=reg_read_data_a, sram_write_en=1.
REQ-028 op 0xA JMP: pc_next=target, pc_load=1.
REQ-029 op 0xB/0xC/0xD BEQ/BGT/BC: pc_load=1 with target only if latched eq/gt/c is 1.
REQ-030 op 0xE IN: write dst with flash_data if bootstrapping else in_gpio.
REQ-031 op 0xF OUT: read_addr_a=dst; out_gpio register <= reg_read_data_a, held until next OUT; out_valid=1 that cycle.
REQ-032 Stack: STACK_DEPTH x PC_W LIFO, pointer 0..STACK_DEPTH; RET pops top to pc_next, pc_load=1.
REQ-033 CALL when full: no push, no pc_load, stack_err<=1; RET when empty: no pop, no pc_load, stack_err<=1.
REQ-034 HALT: halted=1, no fetch, pc_inc=0, all strobes 0; exit only by reset.
REQ-035 reg_read_addr_a/b = a/b for ALU ops, dst for STORE/OUT, else 0.

Reset
REQ-036 arst=1 asynchronously forces state=FETCH_HIGH, instruction=0, high-byte=0, flags=0, stack pointer=0, stack_err=0, halted=0, out_gpio=0.
REQ-037 Reset mid-fetch or mid-EXECUTE discards the partial instruction; no strobe issued while arst=1.
REQ-038 Stack contents need no reset; stack is empty after reset.

Verification
REQ-039 Bytes 0x12,0x34 with flash_valid gaps of 3 cycles -> pc_inc exactly 2 pulses, EXECUTE once, reg_write_en with reg_write_addr=2, alu_opcode=001.
REQ-040 ALU op setting a_equal=1, then 0xB123 with live a_equal=0 -> pc_load=1, pc_next=0x123 (latched flag used).
REQ-041 CALL 0x050 at pc_value=0x00A, then RET -> pc_next=0x050, then 0x00A; stack_err=0.
REQ-042 STACK_DEPTH+1 CALLs -> final CALL gives pc_load=0, stack_err=1; RET on empty after reset -> pc_load=0, stack_err=1.
REQ-043 OUT r3 with r3=0xA5 -> out_gpio=0xA5, out_valid single pulse, value held across next 3 instructions.
REQ-044 0x6100 HALT, then arst pulse mid-HALT -> halted 1, pc_inc 0 until reset; after reset state=00, halted=0.
